// File: rtl/cpu_seq_pkg.sv
// Shared stage encodings and strobe payload for the cpu sequencer and CPU trace logic.
package cpu_seq_pkg;

  localparam int unsigned STAGE_W = 3;
  localparam int unsigned WAIT_W  = 4;

  // Stage encodings, also used by the CPU top for trace output.
  typedef enum logic [STAGE_W-1:0] {
    ST_IF   = 3'd0,
    ST_RR   = 3'd1,
    ST_EX   = 3'd2,
    ST_MA   = 3'd3,
    ST_RW   = 3'd4,
    ST_HALT = 3'd5
  } stage_t;

  // Registered stage strobes driven toward decoder, ALU, RAM and register file.
  typedef struct packed {
    logic decoder_reset;
    logic alu_reset;
    logic ram_we;
    logic reg_we;
  } strobe_t;

  // True when the instruction must pass through the memory-access stage.
  function automatic logic needs_ma(input logic skip_ma, input logic is_load, input logic is_store);
    return !skip_ma || is_load || is_store;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait-state down-counter: loaded on MA entry, done once it reaches zero.
module seq_wait_timer
  import cpu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [WAIT_W-1:0] load_val,
  output logic              done_c
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  // Load has priority; otherwise count down while in MA until zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (run && (count_q != '0)) begin
      count_d = count_q - WAIT_W'(1);
    end
  end

  // Counter register; reset discards any pending wait.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle stage controller: PC register, IF/RR/EX/MA/RW/HALT FSM, stage strobes and counters.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h7FFC),
  parameter bit              SKIP_MA  = 1'b1,
  parameter int unsigned     MEM_WAIT = 0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    npc,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_halt,
  input  logic               reg_we_state,
  input  logic               mem_ready,
  input  logic               stall_req,
  output logic [PC_W-1:0]    pc,
  output logic [STAGE_W-1:0] stage,
  output logic               decoder_reset,
  output logic               alu_reset,
  output logic               ram_we,
  output logic               reg_we,
  output logic               retire,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instret_count
);

  stage_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  strobe_t           strb_q, strb_d;
  logic              retire_q, retire_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              wait_load;
  logic              wait_done_c;

  seq_wait_timer u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .run      (state_q == ST_MA),
    .load_val (WAIT_W'(MEM_WAIT)),
    .done_c   (wait_done_c)
  );

  // Next-state, PC, counter and strobe computation; strobes follow the next state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    retire_d  = 1'b0;
    wait_load = 1'b0;
    strb_d    = '0;

    unique case (state_q)
      ST_IF: begin
        if (!stall_req) begin
          state_d = ST_RR;
        end
      end
      ST_RR: begin
        state_d = ST_EX;
      end
      ST_EX: begin
        if (needs_ma(SKIP_MA, is_load, is_store)) begin
          state_d   = ST_MA;
          wait_load = 1'b1;
        end else begin
          state_d = ST_RW;
        end
      end
      ST_MA: begin
        if (wait_done_c && mem_ready) begin
          state_d = ST_RW;
        end
      end
      ST_RW: begin
        retire_d = 1'b1;
        ret_d    = ret_q + CNT_W'(1);
        if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_IF;
          pc_d    = npc;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IF;
      end
    endcase

    if (state_q != ST_HALT) begin
      cyc_d = cyc_q + CNT_W'(1);
    end

    // A store strobes only on the EX->MA edge, so wait cycles never repeat it.
    strb_d.decoder_reset = (state_d == ST_RR);
    strb_d.alu_reset     = (state_d == ST_EX);
    strb_d.ram_we        = wait_load && is_store;
    strb_d.reg_we        = (state_d == ST_RW) && reg_we_state;
    halted_d             = (state_d == ST_HALT);
  end

  // State, PC, strobe and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IF;
      pc_q     <= RESET_PC;
      strb_q   <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
      cyc_q    <= '0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      strb_q   <= strb_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
    end
  end

  assign pc            = pc_q;
  assign stage         = state_q;
  assign decoder_reset = strb_q.decoder_reset;
  assign alu_reset     = strb_q.alu_reset;
  assign ram_we        = strb_q.ram_we;
  assign reg_we        = strb_q.reg_we;
  assign retire        = retire_q;
  assign halted        = halted_q;
  assign cycle_count   = cyc_q;
  assign instret_count = ret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: driver pushes per-instruction expectations, monitor checks on retire.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  localparam int          PC_W     = 32;
  localparam int          CNT_W    = 32;
  localparam bit          SKIP_MA  = 1'b1;
  localparam int          MEM_WAIT = 2;
  localparam logic [31:0] RST_PC   = 32'h7FFC;

  logic             clk = 1'b0;
  logic             rst;
  logic [PC_W-1:0]  npc;
  logic             is_load, is_store, is_halt, reg_we_state, mem_ready, stall_req;
  logic [PC_W-1:0]  pc;
  logic [2:0]       stage;
  logic             decoder_reset, alu_reset, ram_we, reg_we, retire, halted;
  logic [CNT_W-1:0] cycle_count, instret_count;

  cpu_sequencer #(
    .PC_W(PC_W), .RESET_PC(RST_PC), .SKIP_MA(SKIP_MA), .MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .npc(npc), .is_load(is_load), .is_store(is_store),
    .is_halt(is_halt), .reg_we_state(reg_we_state), .mem_ready(mem_ready),
    .stall_req(stall_req), .pc(pc), .stage(stage), .decoder_reset(decoder_reset),
    .alu_reset(alu_reset), .ram_we(ram_we), .reg_we(reg_we), .retire(retire),
    .halted(halted), .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int instret;
    int cyc;
    int if_n;
    int ma_n;
    int ramwe;
    int regwe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: architectural view since the last reset.
  logic [31:0] model_pc;
  int          model_cyc;
  int          model_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: tallies per-instruction stage/strobe activity and compares on each retire pulse.
  initial begin : monitor
    int if_n, rr_n, ex_n, ma_n, dr_in, dr_all, ar_in, ar_all, rw_first, rw_all, rg_in, rg_all;
    logic [2:0] prev;
    exp_t e;
    prev = 3'd7;
    if_n = 0; rr_n = 0; ex_n = 0; ma_n = 0; dr_in = 0; dr_all = 0; ar_in = 0; ar_all = 0;
    rw_first = 0; rw_all = 0; rg_in = 0; rg_all = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && retire === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("retire_pc", pc, e.pc);
          chk("instret_count", instret_count, e.instret);
          chk("cycle_count", cycle_count, e.cyc);
          chk("if_cycles", if_n, e.if_n);
          chk("rr_cycles", rr_n, 1);
          chk("ex_cycles", ex_n, 1);
          chk("ma_cycles", ma_n, e.ma_n);
          chk("decoder_reset_in_rr", {dr_in, dr_all}, {32'd1, 32'd1});
          chk("alu_reset_in_ex", {ar_in, ar_all}, {32'd1, 32'd1});
          chk("ram_we_first_ma", {rw_first, rw_all}, {e.ramwe, e.ramwe});
          chk("reg_we_in_rw", {rg_in, rg_all}, {e.regwe, e.regwe});
        end
      end
      if (rst !== 1'b1 || retire === 1'b1) begin
        if_n = 0; rr_n = 0; ex_n = 0; ma_n = 0; dr_in = 0; dr_all = 0; ar_in = 0; ar_all = 0;
        rw_first = 0; rw_all = 0; rg_in = 0; rg_all = 0;
      end
      if (stage == ST_IF) if_n++;
      if (stage == ST_RR) rr_n++;
      if (stage == ST_EX) ex_n++;
      if (stage == ST_MA) ma_n++;
      if (decoder_reset) begin dr_all++; if (stage == ST_RR) dr_in++; end
      if (alu_reset)     begin ar_all++; if (stage == ST_EX) ar_in++; end
      if (ram_we)        begin rw_all++; if (stage == ST_MA && prev != ST_MA) rw_first++; end
      if (reg_we)        begin rg_all++; if (stage == ST_RW) rg_in++; end
      prev = stage;
    end
  end

  // Hold reset for n cycles, check the reset state, then release and reset the model.
  task automatic do_reset(input int n);
    rst = 1'b0;
    stall_req = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_stage", stage, ST_IF);
    chk("rst_pc", pc, RST_PC);
    chk("rst_flags", {decoder_reset, alu_reset, ram_we, reg_we, retire, halted}, 64'd0);
    chk("rst_counters", {cycle_count, instret_count}, 64'd0);
    rst = 1'b1;
    model_pc  = RST_PC;
    model_cyc = 0;
    model_ret = 0;
  endtask

  // Issue one instruction starting in its first IF cycle; returns in the first cycle after RW.
  task automatic run_instr(input int kind, input int stall_n, input int low_n,
                           input logic [31:0] npc_v, input bit rws, input bit halt);
    exp_t e;
    bit   mem, seen_rw, done;
    int   if_c, ma_c;
    logic [2:0] st;
    mem = (SKIP_MA == 1'b0) || (kind != 0);
    model_cyc += stall_n + 4 + (mem ? (MEM_WAIT + 1 + low_n) : 0);
    model_ret += 1;
    if (!halt) model_pc = npc_v;
    e.pc = model_pc; e.instret = model_ret; e.cyc = model_cyc; e.if_n = stall_n + 1;
    e.ma_n = mem ? (MEM_WAIT + 1 + low_n) : 0;
    e.ramwe = (kind == 2) ? 1 : 0;
    e.regwe = rws ? 1 : 0;
    exp_q.push_back(e);
    // Decoder outputs are junk until EX; real values are applied during RR.
    is_load = 1'($urandom); is_store = 1'($urandom); is_halt = 1'($urandom);
    reg_we_state = 1'($urandom); npc = $urandom; mem_ready = 1'($urandom);
    stall_req = (stall_n > 0);
    if_c = 1; ma_c = 0; seen_rw = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      st = stage;
      if (seen_rw && st != ST_RW) begin
        done = 1;
      end else begin
        if (st != ST_MA) mem_ready = 1'($urandom);
        case (st)
          ST_IF: begin stall_req = (if_c < stall_n); if_c++; end
          ST_RR: begin
            stall_req = 1'($urandom);
            is_load = (kind == 1); is_store = (kind == 2); is_halt = halt;
            reg_we_state = rws; npc = npc_v;
          end
          ST_MA: begin
            stall_req = 1'($urandom);
            if (ma_c < MEM_WAIT) mem_ready = 1'($urandom);
            else mem_ready = (ma_c >= MEM_WAIT + low_n);
            ma_c++;
          end
          ST_RW: begin seen_rw = 1; stall_req = 1'($urandom); end
          default: stall_req = 1'($urandom);
        endcase
      end
    end
    if (!done) chk("instr_timeout", 64'd0, 64'd1);
    stall_req = 1'b0;
  endtask

  initial begin : main
    int ret_n, bad, found;
    rst = 1'b0; npc = '0; is_load = 0; is_store = 0; is_halt = 0;
    reg_we_state = 0; mem_ready = 0; stall_req = 0;

    do_reset(2);
    run_instr(0, 0, 0, 32'h8000, 1'b1, 1'b0);
    run_instr(2, 0, 1, 32'h8004, 1'b0, 1'b0);
    run_instr(0, 3, 0, 32'h8008, 1'b0, 1'b0);
    run_instr(1, 1, 2, 32'h800C, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'b0);
    end
    run_instr(0, 0, 0, 32'h8010, 1'b1, 1'b0);
    run_instr(0, 1, 0, 32'hDEAD_BEEC, 1'b1, 1'b1);

    // HALT: frozen PC and cycle counter, no further retire.
    chk("halt_stage", stage, ST_HALT);
    chk("halted", halted, 64'd1);
    chk("halt_pc", pc, 32'h8010);
    ret_n = 0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      stall_req = 1'($urandom);
      if (retire) ret_n++;
      if (cycle_count != CNT_W'(model_cyc) || stage != ST_HALT || pc != 32'h8010) bad++;
    end
    chk("halt_no_retire", ret_n, 64'd0);
    chk("halt_frozen", bad, 64'd0);

    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'b0);
    end

    // Reset in the first MA cycle of a store with wait states pending.
    is_store = 1'b1; is_load = 1'b0; is_halt = 1'b0; mem_ready = 1'b0; stall_req = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (stage == ST_MA) found = 1;
    end
    chk("midma_reached", found, 64'd1);
    chk("midma_ram_we", ram_we, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("midma_rst_stage", stage, ST_IF);
    chk("midma_rst_ram_we", ram_we, 64'd0);
    chk("midma_rst_counters", {cycle_count, instret_count}, 64'd0);
    chk("midma_rst_pc", pc, RST_PC);
    rst = 1'b1;
    model_pc = RST_PC; model_cyc = 0; model_ret = 0;
    run_instr(2, 0, 0, 32'h9000, 1'b0, 1'b0);
    run_instr(0, 2, 0, 32'h9004, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
